uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Parametrised UART transceiver replacing the fixed 8N1 baud generator / receiver / transmitter trio beneath the top level.
- Configurable data width, stop bits and baud divisor.
- Valid/ready handshakes on both directions, one-entry RX holding register with error flags.
- Sits between the debug unit and the rx/tx pins, one clock domain.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 19200, line rate in bit/s.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits sent by TX; legal values 1 or 2. RX checks the first stop bit only.
- PARITY_ODD, 0, parity sense when UART_PARITY_EN is defined: 0 = even, 1 = odd.

Ports:
- clock, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous, active-low reset.
- rx, in, 1, serial input, asynchronous to clock.
- tx, out, 1, serial output; idle high.
- tx_data, in, DATA_BITS, byte to send.
- tx_valid, in, 1, tx_data valid.
- tx_ready, out, 1, transmitter can accept a byte.
- tx_busy, out, 1, frame in progress.
- rx_data, out, DATA_BITS, received byte.
- rx_valid, out, 1, rx_data and the error flags are valid.
- rx_ready, in, 1, consumer accepts rx_data.
- rx_frame_err, out, 1, first stop bit sampled 0.
- rx_parity_err, out, 1, parity mismatch.
- rx_overrun, out, 1, a frame was dropped because the holding register was full. Sticky.

Behaviour:
- Reset (reset=0, takes effect immediately, also mid-frame):
  - Outputs: tx=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, all error flags 0.
  - Internal: both FSMs IDLE, baud counter 0, rx synchroniser 2'b11.
- Baud tick:
  - DIV = max(1, CLK_HZ/(BAUD*16)), integer floor.
  - Free-running counter 0..DIV-1; tick is a 1-cycle pulse when the counter wraps. Oversampling is 16 ticks per bit.
- RX path: rx passes through a 2-flop synchroniser; all decisions use the synchronised value.
- RX FSM states IDLE, START, DATA, PARITY, STOP.
  - IDLE: synced rx=0 -> START, tick count cleared.
  - START: at tick 8, sample the line.
    - If 1: glitch, go to IDLE, no output.
    - If 0: clear count, go to DATA.
  - DATA: sample every 16th tick, LSB first. After DATA_BITS samples -> PARITY if the macro is defined, else STOP.
  - PARITY: sample at the 16th tick, compute the mismatch -> STOP.
  - STOP: sample at the 16th tick; frame_err = ~sample. Load the holding register -> IDLE.
- Holding register load:
  - If rx_valid=0, or rx_valid&rx_ready in the same cycle: load rx_data and flags, rx_valid=1.
  - Else: keep the old data, drop the new frame, rx_overrun=1.
- rx_valid&rx_ready clears rx_valid and rx_overrun on the next edge. An error frame still asserts rx_valid.
- TX handshake: a byte is accepted on tx_valid&tx_ready; tx_ready and tx_busy change on the next edge.
- TX FSM states IDLE, START, DATA, PARITY, STOP.
  - Acceptance drives tx=0 (start bit) from the next cycle.
  - Each bit lasts 16 ticks; the bit counter advances on ticks only.
  - Bit order: data LSB first, then parity (if enabled), then STOP_BITS high bits.
  - At the end of the last stop bit: IDLE, tx_ready=1, tx_busy=0.
- Width rules:
  - Counters: 4-bit tick count; bit index of clog2(DATA_BITS+1) bits.
  - Parity is the XOR of the data bits, XOR PARITY_ODD.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: both FSMs include the PARITY state; rx_parity_err reports the mismatch.
- Undefined: PARITY state absent; frames carry no parity bit; rx_parity_err is tied 0.

Decomposition:
- Package uart_pkg:
  - rx/tx state enum (IDLE, START, DATA, PARITY, STOP).
  - OVERSAMPLE=16 and MID_SAMPLE=8 constants.
  - Divisor computation function.
- One sub-module, uart_baud_gen (parameter DIV): clock, reset, tick output. RX and TX FSMs stay in uart_core.

Test Plan:
All scenarios use CLK_HZ=7372800 and BAUD=115200, giving DIV=4 and 64 clocks per bit.
- Loopback tx->rx, send 0xA5, 8N1: tx shows 0,1,0,1,0,0,1,0,1,1, each bit 64 cycles. Then rx_valid=1, rx_data=0xA5, all flags 0, tx_ready returns to 1.
- Glitch: rx low for 12 cycles then high: no rx_valid, RX FSM back in IDLE, next frame 0x5A received correctly.
- Frame error: drive 0x3C with stop bit 0: rx_valid=1, rx_data=0x3C, rx_frame_err=1.
- Overrun: rx_ready=0, send 0x11 then 0x22: rx_data stays 0x11, rx_overrun=1. Handshake clears both rx_valid and rx_overrun.
- Parity, UART_PARITY_EN defined, PARITY_ODD=0: send 0x07 with parity bit 0 -> rx_parity_err=1. Send 0x07 with parity bit 1 -> rx_parity_err=0.
- Reset during TX data bit 3: tx=1, tx_ready=1, tx_busy=0 immediately. After release, 0xC3 transmits cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART.
// UART_PARITY_EN adds the PARITY state to both frame FSMs.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;
`endif

  function automatic int calc_div(
    input int clk_hz,
    input int baud
  );
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator.
// Emits a one-cycle tick each time the counter wraps.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == W'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_core.sv
// UART transceiver: 16x oversampled RX with holding register, TX.
// Define UART_PARITY_EN to add a parity bit to every frame.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 19200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [3:0]    MID_CNT  = 4'(MID_SAMPLE - 1);
  localparam logic [3:0]    LAST_CNT = 4'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic tick;

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  uart_state_e          rx_st_q, rx_st_d;
  logic [3:0]           rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_load, rx_ferr_new;
  logic                 rx_hs;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_vld_q, rx_ferr_q, rx_ovr_q;
`ifdef UART_PARITY_EN
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_perr_hold_q;
`endif

  always_comb begin
    rx_st_d     = rx_st_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_load     = 1'b0;
    rx_ferr_new = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d   = rx_perr_q;
`endif
    if (rx_st_q != ST_IDLE && tick) rx_cnt_d = rx_cnt_q + 4'd1;
    unique case (rx_st_q)
      ST_IDLE: begin
        if (!rx_s) begin
          rx_st_d  = ST_START;
          rx_cnt_d = '0;
`ifdef UART_PARITY_EN
          rx_perr_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (tick && rx_cnt_q == MID_CNT) begin
          if (rx_s) begin
            rx_st_d = ST_IDLE;
          end else begin
            rx_st_d  = ST_DATA;
            rx_cnt_d = '0;
            rx_bit_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (tick && rx_cnt_q == LAST_CNT) begin
          rx_sh_d  = {rx_s, rx_sh_q[DATA_BITS-1:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_st_d = ST_PARITY;
`else
            rx_st_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tick && rx_cnt_q == LAST_CNT) begin
          rx_perr_d = (^rx_sh_q) ^ 1'(PARITY_ODD) ^ rx_s;
          rx_st_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick && rx_cnt_q == LAST_CNT) begin
          rx_load     = 1'b1;
          rx_ferr_new = ~rx_s;
          rx_st_d     = ST_IDLE;
        end
      end
      default: rx_st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_st_q  <= ST_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
`ifdef UART_PARITY_EN
      rx_perr_q <= 1'b0;
`endif
    end else begin
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
`ifdef UART_PARITY_EN
      rx_perr_q <= rx_perr_d;
`endif
    end
  end

  assign rx_hs = rx_vld_q & rx_ready;

  // A frame finishing while the old one is still unread is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      rx_ovr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_hold_q <= 1'b0;
`endif
    end else if (rx_load) begin
      if (!rx_vld_q || rx_hs) begin
        rx_data_q <= rx_sh_q;
        rx_vld_q  <= 1'b1;
        rx_ferr_q <= rx_ferr_new;
`ifdef UART_PARITY_EN
        rx_perr_hold_q <= rx_perr_q;
`endif
        if (rx_hs) rx_ovr_q <= 1'b0;
      end else begin
        rx_ovr_q <= 1'b1;
      end
    end else if (rx_hs) begin
      rx_vld_q <= 1'b0;
      rx_ovr_q <= 1'b0;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_vld_q;
  assign rx_frame_err = rx_ferr_q;
  assign rx_overrun   = rx_ovr_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_perr_hold_q;
`else
  assign rx_parity_err = 1'b0;
`endif

  uart_state_e          tx_st_q, tx_st_d;
  logic [3:0]           tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_stop_q, tx_stop_d;
  logic                 tx_q, tx_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_stop_d = tx_stop_q;
    tx_d      = tx_q;
`ifdef UART_PARITY_EN
    tx_par_d  = tx_par_q;
`endif
    if (tx_st_q != ST_IDLE && tick) tx_cnt_d = tx_cnt_q + 4'd1;
    unique case (tx_st_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          tx_st_d  = ST_START;
          tx_cnt_d = '0;
          tx_sh_d  = tx_data;
          tx_d     = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_d = (^tx_data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      ST_START: begin
        if (tick && tx_cnt_q == LAST_CNT) begin
          tx_st_d  = ST_DATA;
          tx_bit_d = '0;
          tx_d     = tx_sh_q[0];
        end
      end
      ST_DATA: begin
        if (tick && tx_cnt_q == LAST_CNT) begin
          if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_st_d = ST_PARITY;
            tx_d    = tx_par_q;
`else
            tx_st_d   = ST_STOP;
            tx_d      = 1'b1;
            tx_stop_d = 1'b0;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tick && tx_cnt_q == LAST_CNT) begin
          tx_st_d   = ST_STOP;
          tx_d      = 1'b1;
          tx_stop_d = 1'b0;
        end
      end
`endif
      ST_STOP: begin
        if (tick && tx_cnt_q == LAST_CNT) begin
          if (STOP_BITS == 1 || tx_stop_q) tx_st_d = ST_IDLE;
          else                            tx_stop_d = 1'b1;
        end
      end
      default: tx_st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_st_q   <= ST_IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_stop_q <= 1'b0;
      tx_q      <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q  <= 1'b0;
`endif
    end else begin
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_stop_q <= tx_stop_d;
      tx_q      <= tx_d;
`ifdef UART_PARITY_EN
      tx_par_q  <= tx_par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (tx_st_q == ST_IDLE);
  assign tx_busy  = ~tx_ready;

endmodule

// File: tb/tb_uart_core.sv
// Randomised bench for uart_core against a frame-level line model.
// Parity scenarios are built only when UART_PARITY_EN is defined.
module tb_uart_core;

  localparam int CLK_HZ  = 7372800;
  localparam int BAUD    = 115200;
  localparam int DB      = 8;
  localparam int SB      = 1;
  localparam int PODD    = 0;
  localparam int BIT_CYC = 64;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 1 + DB + PB + SB;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          tx;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx_busy;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic          rx_frame_err, rx_parity_err, rx_overrun;
  logic          loop_en = 1'b0;
  logic          rx_drv = 1'b1;
  logic          rx_line;

  int n_chk  = 0;
  int n_fail = 0;

  assign rx_line = loop_en ? tx : rx_drv;

  always #5 clock = ~clock;

  uart_core #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (DB),
    .STOP_BITS (SB),
    .PARITY_ODD(PODD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx_line),
    .tx           (tx),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_overrun   (rx_overrun)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic par(input logic [DB-1:0] d);
    return 1'(($countones(d) + PODD) % 2);
  endfunction

  // Expected line levels, one per bit period, start bit first.
  function automatic logic [15:0] frame_bits(input logic [DB-1:0] d);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1+i] = d[i];
`ifdef UART_PARITY_EN
    f[1+DB] = par(d);
`endif
    return f & 16'((1 << NB) - 1);
  endfunction

  task automatic send_tx(input logic [DB-1:0] d);
    int w = 0;
    while (!tx_ready && w < 2000) begin
      @(negedge clock);
      w++;
    end
    if (!tx_ready) chk("tx_ready_wait", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic capture_tx(
    output logic [15:0] bits,
    output int          e0,
    output int          e1
  );
    int   w  = 0;
    int   ne = 0;
    logic prev;
    bits = '0;
    e0   = -1;
    e1   = -1;
    while (tx !== 1'b0 && w < 300) begin
      @(negedge clock);
      w++;
    end
    if (tx !== 1'b0) begin
      chk("tx_start_seen", tx, 0);
      return;
    end
    prev = 1'b0;
    for (int c = 1; c <= 32 + BIT_CYC * (NB - 1); c++) begin
      @(negedge clock);
      if (tx !== prev) begin
        if (ne == 0) e0 = c;
        else if (ne == 1) e1 = c;
        ne++;
        prev = tx;
      end
      if (c >= 32 && (c - 32) % BIT_CYC == 0)
        bits[(c-32)/BIT_CYC] = tx;
    end
  endtask

  task automatic wait_rx(input int bound);
    int w = 0;
    while (!rx_valid && w < bound) begin
      @(negedge clock);
      w++;
    end
    if (!rx_valid) chk("rx_valid_wait", rx_valid, 1);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  // A zero stop bit is cut short so the follow-on false start is
  // sampled high and rejected as a glitch.
  task automatic drive_frame(
    input logic [DB-1:0] d,
    input logic          pbit,
    input logic          sbit
  );
    rx_drv = 1'b0;
    repeat (BIT_CYC) @(negedge clock);
    for (int i = 0; i < DB; i++) begin
      rx_drv = d[i];
      repeat (BIT_CYC) @(negedge clock);
    end
`ifdef UART_PARITY_EN
    rx_drv = pbit;
    repeat (BIT_CYC) @(negedge clock);
`else
    if (pbit) rx_drv = 1'b0;
`endif
    rx_drv = sbit;
    repeat (sbit ? BIT_CYC : 48) @(negedge clock);
    rx_drv = 1'b1;
    repeat (96) @(negedge clock);
  endtask

  task automatic check_rx(
    input string         tag,
    input logic [DB-1:0] d,
    input logic          ferr,
    input logic          perr
  );
    wait_rx(400);
    chk({tag, "_valid"}, rx_valid, 1);
    chk({tag, "_data"}, rx_data, d);
    chk({tag, "_ferr"}, rx_frame_err, ferr);
    chk({tag, "_perr"}, rx_parity_err, perr);
  endtask

  task automatic loop_byte(input string tag, input logic [DB-1:0] d);
    logic [15:0] bits;
    int          e0, e1;
    send_tx(d);
    capture_tx(bits, e0, e1);
    chk({tag, "_frame"}, bits, frame_bits(d));
    check_rx(tag, d, 1'b0, 1'b0);
    consume();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int          e0, e1, w;
    logic [DB-1:0] d;
    logic        s, p, pe;

    #3 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_tx", tx, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_flags", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    reset = 1'b1;
    @(negedge clock);

    loop_en = 1'b1;
    send_tx(8'hA5);
    chk("a5_busy", tx_busy, 1);
    capture_tx(bits, e0, e1);
    chk("a5_frame", bits, frame_bits(8'hA5));
    chk("a5_bit_len", e1 - e0, BIT_CYC);
    check_rx("a5", 8'hA5, 1'b0, 1'b0);
    chk("a5_ovr", rx_overrun, 0);
    w = 0;
    while (!tx_ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk("a5_tx_ready", tx_ready, 1);
    consume();
    chk("a5_rx_cleared", rx_valid, 0);

    for (int i = 0; i < 6; i++) begin
      d = DB'($urandom);
      loop_byte("loop_rnd", d);
    end

    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (100) @(negedge clock);

    rx_drv = 1'b0;
    repeat (12) @(negedge clock);
    rx_drv = 1'b1;
    repeat (200) @(negedge clock);
    chk("glitch_no_valid", rx_valid, 0);
    drive_frame(8'h5A, par(8'h5A), 1'b1);
    check_rx("post_glitch", 8'h5A, 1'b0, 1'b0);
    consume();

    drive_frame(8'h3C, par(8'h3C), 1'b0);
    check_rx("ferr", 8'h3C, 1'b1, 1'b0);
    consume();

    drive_frame(8'h11, par(8'h11), 1'b1);
    drive_frame(8'h22, par(8'h22), 1'b1);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", rx_overrun, 1);
    consume();
    chk("ovr_valid_clr", rx_valid, 0);
    chk("ovr_flag_clr", rx_overrun, 0);

    for (int i = 0; i < 8; i++) begin
      d  = DB'($urandom);
      s  = ($urandom_range(3) != 0);
      p  = par(d);
      pe = 1'b0;
`ifdef UART_PARITY_EN
      if ($urandom_range(1) == 1) begin
        p  = ~p;
        pe = 1'b1;
      end
`endif
      drive_frame(d, p, s);
      check_rx("drv_rnd", d, ~s, pe);
      consume();
    end

`ifdef UART_PARITY_EN
    drive_frame(8'h07, 1'b0, 1'b1);
    check_rx("par_bad", 8'h07, 1'b0, 1'b1);
    consume();
    drive_frame(8'h07, 1'b1, 1'b1);
    check_rx("par_good", 8'h07, 1'b0, 1'b0);
    consume();
`endif

    loop_en = 1'b1;
    send_tx(8'hC3);
    repeat (32 + BIT_CYC * 4) @(negedge clock);
    chk("mid_busy", tx_busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_rxv", rx_valid, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    loop_byte("after_rst", 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
